gpi_arbiter: RTL and testbench

//  Shares one general peripheral interface (GPI) target port among NUM_REQ requesters
//  (e.g. the AXI-to-GPI bridge and the debug module) in front of CLINT/timer registers.

---
 rtl/gpi_pkg.sv | 13 +
 rtl/rr_picker.sv | 30 +++
 rtl/gpi_arbiter.sv | 146 ++++++++++++++
 tb/tb_gpi_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpi_pkg.sv
// Shared GPI definitions: default bus widths and the arbiter FSM encoding.
package gpi_pkg;

  localparam int unsigned GPI_ADDR_W = 32;
  localparam int unsigned GPI_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } gpi_state_e;

endpackage : gpi_pkg

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping mod NUM_REQ.
module rr_picker #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDX_W-1:0]   idx_c,
  output logic               any_c
);

  int unsigned k;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    k       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (!any_c && req[IDX_W'(k)]) begin
        any_c               = 1'b1;
        grant_c[IDX_W'(k)]  = 1'b1;
        idx_c               = IDX_W'(k);
      end
    end
  end

endmodule : rr_picker

// File: rtl/gpi_arbiter.sv
// Round-robin arbiter sharing one GPI target port, one transaction in flight.
// Optional grant locking for atomic multi-access sequences: define GPI_ARB_LOCK_EN.
module gpi_arbiter
  import gpi_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = GPI_ADDR_W,
  parameter int unsigned DATA_W  = GPI_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef GPI_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      gpi_read,
  output logic                      gpi_write,
  output logic [ADDR_W-1:0]         gpi_addr,
  output logic [DATA_W-1:0]         gpi_wdata,
  input  logic [DATA_W-1:0]         gpi_rdata
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  gpi_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   idx_q;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;

  logic [NUM_REQ-1:0] eligible_c;
  logic [NUM_REQ-1:0] grant_c;
  logic [IDX_W-1:0]   win_idx_c;
  logic               win_any_c;
  logic               accept_c;

`ifdef GPI_ARB_LOCK_EN
  logic               lock_q;
  logic               owner_vld_q;
  logic [IDX_W-1:0]   owner_idx_q;

  // While a lock is held only the owner may be granted.
  always_comb begin
    eligible_c = req_valid;
    if (owner_vld_q) eligible_c = req_valid & (NUM_REQ'(1) << owner_idx_q);
  end
`else
  always_comb eligible_c = req_valid;
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req     (eligible_c),
    .ptr     (ptr_q),
    .grant_c (grant_c),
    .idx_c   (win_idx_c),
    .any_c   (win_any_c)
  );

  assign accept_c = (state_q == ST_IDLE) && win_any_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (win_any_c) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Accepted-transaction capture and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      idx_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept_c) begin
      ptr_q   <= win_idx_c;
      idx_q   <= win_idx_c;
      wr_q    <= req_write[win_idx_c];
      addr_q  <= req_addr[win_idx_c*ADDR_W +: ADDR_W];
      wdata_q <= req_wdata[win_idx_c*DATA_W +: DATA_W];
    end
  end

`ifdef GPI_ARB_LOCK_EN
  // Ownership follows the lock bit of the transaction that just completed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q      <= 1'b0;
      owner_vld_q <= 1'b0;
      owner_idx_q <= '0;
    end else begin
      if (accept_c) lock_q <= req_lock[win_idx_c];
      if (state_q == ST_RESP) begin
        owner_vld_q <= lock_q;
        owner_idx_q <= idx_q;
      end
    end
  end
`endif

  // Output decode
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    gpi_read  = 1'b0;
    gpi_write = 1'b0;
    gpi_addr  = '0;
    gpi_wdata = '0;
    case (state_q)
      ST_IDLE:  req_ready = grant_c;
      ST_ISSUE: begin
        gpi_read  = !wr_q;
        gpi_write = wr_q;
        gpi_addr  = addr_q;
        if (wr_q) gpi_wdata = wdata_q;
      end
      ST_RESP: begin
        rsp_valid = NUM_REQ'(1) << idx_q;
        if (!wr_q) rsp_rdata = gpi_rdata;
      end
      default: ;
    endcase
  end

endmodule : gpi_arbiter

// File: tb/tb_gpi_arbiter.sv
// Directed self-checking bench for gpi_arbiter with NUM_REQ=2 (lock scenario follows GPI_ARB_LOCK_EN).
module tb_gpi_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
`ifdef GPI_ARB_LOCK_EN
  logic [NR-1:0]   req_lock;
`endif
  logic [NR-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            gpi_read;
  logic            gpi_write;
  logic [AW-1:0]   gpi_addr;
  logic [DW-1:0]   gpi_wdata;
  logic [DW-1:0]   gpi_rdata;
  logic [DW-1:0]   periph_val;

  int n_assert = 0;
  int n_fail   = 0;

  gpi_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef GPI_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .gpi_read  (gpi_read),
    .gpi_write (gpi_write),
    .gpi_addr  (gpi_addr),
    .gpi_wdata (gpi_wdata),
    .gpi_rdata (gpi_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered peripheral: read data appears the cycle after the strobe.
  always @(posedge clk) gpi_rdata <= gpi_read ? periph_val : 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    periph_val = 32'h0;
`ifdef GPI_ARB_LOCK_EN
    req_lock   = '0;
`endif

    // Reset state
    tick();
    tick();
    chk("rst_ready",  64'(req_ready), 64'h0);
    chk("rst_rsp",    64'(rsp_valid), 64'h0);
    chk("rst_strobe", 64'({gpi_read, gpi_write}), 64'h0);
    chk("rst_addr",   64'(gpi_addr), 64'h0);
    chk("rst_rdata",  64'(rsp_rdata), 64'h0);
    rst_n = 1'b1;
    tick();

    // 1: single read from req0
    req_valid      = 2'b01;
    req_write      = 2'b00;
    req_addr[31:0] = 32'h0200_BFF8;
    periph_val     = 32'h1234_5678;
    #1;
    chk("t1_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    #1;
    chk("t1_read",  64'({gpi_read, gpi_write}), 64'h2);
    chk("t1_addr",  64'(gpi_addr), 64'h0200_BFF8);
    chk("t1_rdy_issue", 64'(req_ready), 64'h0);
    tick();
    chk("t1_rsp",   64'(rsp_valid), 64'h1);
    chk("t1_rdata", 64'(rsp_rdata), 64'h1234_5678);
    chk("t1_nostrobe", 64'({gpi_read, gpi_write}), 64'h0);
    tick();
    chk("t1_idle_rsp", 64'(rsp_valid), 64'h0);
    chk("t1_idle_rdy", 64'(req_ready), 64'h0);

    // 2: simultaneous writes, req0 then req1
    do_reset();
    req_valid = 2'b11;
    req_write = 2'b11;
    req_addr  = {32'h0000_0008, 32'h0000_0004};
    req_wdata = {32'h0000_00BB, 32'h0000_00AA};
    #1;
    chk("t2_ready0", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b10;
    #1;
    chk("t2_wr0",    64'({gpi_read, gpi_write}), 64'h1);
    chk("t2_addr0",  64'(gpi_addr), 64'h4);
    chk("t2_wdata0", 64'(gpi_wdata), 64'hAA);
    tick();
    chk("t2_rsp0",   64'(rsp_valid), 64'h1);
    chk("t2_rdata0", 64'(rsp_rdata), 64'h0);
    tick();
    chk("t2_ready1", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    #1;
    chk("t2_wr1",    64'({gpi_read, gpi_write}), 64'h1);
    chk("t2_addr1",  64'(gpi_addr), 64'h8);
    chk("t2_wdata1", 64'(gpi_wdata), 64'hBB);
    tick();
    chk("t2_rsp1",   64'(rsp_valid), 64'h2);
    tick();

    // 3: both requesters saturating; grants alternate starting at req0
    req_valid  = 2'b11;
    req_write  = 2'b00;
    periph_val = 32'hA5A5_0001;
    #1;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("t3_grant%0d", k), 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      tick();
      chk($sformatf("t3_rsp%0d", k), 64'(rsp_valid), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick();
    end
    req_valid = 2'b00;
    tick();

    // 4: reset while a req0 read is in ISSUE
    req_valid      = 2'b01;
    req_write      = 2'b00;
    req_addr[31:0] = 32'h0000_0010;
    #1;
    chk("t4_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    rst_n     = 1'b0;
    tick();
    chk("t4_nostrobe", 64'({gpi_read, gpi_write}), 64'h0);
    chk("t4_norsp",    64'(rsp_valid), 64'h0);
    rst_n = 1'b1;
    tick();
    chk("t4_nostrobe2", 64'({gpi_read, gpi_write}), 64'h0);
    chk("t4_norsp2",    64'(rsp_valid), 64'h0);
    req_valid = 2'b11;
    #1;
    chk("t4_next_req0", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    tick();
    tick();

    // 5/6: req0 read 0x4000 (locked when enabled), then write 0x4004 competing with req1
    req_valid      = 2'b01;
    req_write      = 2'b00;
    req_addr[31:0] = 32'h0000_4000;
`ifdef GPI_ARB_LOCK_EN
    req_lock       = 2'b01;
`endif
    #1;
    chk("t5_ready_a", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    #1;
    chk("t5_addr_a", 64'(gpi_addr), 64'h4000);
    tick();
    chk("t5_rsp_a", 64'(rsp_valid), 64'h1);
    tick();
    req_valid = 2'b11;
    req_write = 2'b11;
    req_addr  = {32'h0000_0008, 32'h0000_4004};
    req_wdata = {32'h0000_00BB, 32'h0000_CAFE};
`ifdef GPI_ARB_LOCK_EN
    req_lock  = 2'b00;
    #1;
    chk("t5_owner_only", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b10;
    #1;
    chk("t5_addr_b", 64'(gpi_addr), 64'h4004);
    chk("t5_wdata_b", 64'(gpi_wdata), 64'hCAFE);
    tick();
    chk("t5_rsp_b", 64'(rsp_valid), 64'h1);
    tick();
    chk("t5_req1_after", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    #1;
    chk("t5_addr_req1", 64'(gpi_addr), 64'h8);
`else
    #1;
    chk("t6_req1_between", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b01;
    #1;
    chk("t6_addr_req1", 64'(gpi_addr), 64'h8);
    tick();
    chk("t6_rsp_req1", 64'(rsp_valid), 64'h2);
    tick();
    chk("t6_req0_next", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    #1;
    chk("t6_addr_b", 64'(gpi_addr), 64'h4004);
    chk("t6_wdata_b", 64'(gpi_wdata), 64'hCAFE);
`endif
    tick();
    tick();
    chk("end_idle", 64'({gpi_read, gpi_write, rsp_valid}), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_gpi_arbiter
